// File: rtl/inst_encoder_loader_if.sv
// Descriptor-in / instruction-word-out stream bundle for the instruction encoder loader.
interface inst_encoder_loader_if #(
    parameter int ADDR_W = 32
);
    // Descriptor stream
    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic [3:0]          op_sel;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic signed [63:0]  imm;

    // Encoded word stream towards the instruction-memory write port
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_inst;
    logic [ADDR_W-1:0]   out_addr;

    // Producer of descriptors and consumer of encoded words
    modport master (
        output in_valid, in_last, op_sel, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr
    );

    // The encoder loader itself
    modport slave (
        input  in_valid, in_last, op_sel, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr
    );
endinterface

// File: rtl/inst_encoder_loader.sv
// Instruction encoder loader: range-checks symbolic RV64I descriptors, packs them
// into 32-bit words and streams them to instruction memory at consecutive byte
// addresses. Rejected descriptors are consumed without emitting a word.
module inst_encoder_loader #(
    parameter int ADDR_W = 32,
    parameter int ERR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    inst_encoder_loader_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               last_acc;
    logic [ADDR_W-1:0]  addr_cnt;

    logic               vld_p1;
    logic [31:0]        inst_p1;
    logic [ADDR_W-1:0]  addr_p1;

    logic               accept;
    logic               drain;
    logic               enc_ok;
    logic [31:0]        enc_word;

    // True when v is the sign extension of its low 12 bits
    function automatic logic fits12(input logic signed [63:0] v);
        return (&v[63:11]) || (~|v[63:11]);
    endfunction

    // True when v is the sign extension of its low 20 bits
    function automatic logic fits20(input logic signed [63:0] v);
        return (&v[63:19]) || (~|v[63:19]);
    endfunction

    // Returns {legal, word}; unused register fields are left at zero
    function automatic logic [32:0] encode(
        input logic [3:0]         op,
        input logic [4:0]         f_rd,
        input logic [4:0]         f_rs1,
        input logic [4:0]         f_rs2,
        input logic signed [63:0] v
    );
        logic ok12;
        logic ok20;
        logic [32:0] r;
        ok12 = fits12(v);
        ok20 = fits20(v);
        r = '0;
        case (op)
            4'd0: r = {ok12, v[11:0], f_rs1, 3'b011, f_rd, OPC_LOAD};
            4'd1: r = {ok12, v[11:0], f_rs1, 3'b010, f_rd, OPC_LOAD};
            4'd2: r = {ok12, v[11:5], f_rs2, f_rs1, 3'b011, v[4:0], OPC_STORE};
            4'd3: r = {ok12, v[11:5], f_rs2, f_rs1, 3'b010, v[4:0], OPC_STORE};
            4'd4: r = {ok12, v[11:0], f_rs1, 3'b000, f_rd, OPC_OPIMM};
            4'd5: r = {ok12, v[11:0], f_rs1, 3'b010, f_rd, OPC_OPIMM};
            4'd6: r = {ok12, v[11:0], f_rs1, 3'b000, f_rd, OPC_JALR};
            4'd7: r = {ok12, v[11], v[9:4], f_rs2, f_rs1, 3'b000, v[3:0], v[10], OPC_BRANCH};
            4'd8: r = {ok20, v[19], v[9:0], v[10], v[18:11], f_rd, OPC_JAL};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Saturating error-count increment
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign busy          = (state == LOAD);
    assign done          = (state == DONE);
    assign bus.in_ready  = busy && (!vld_p1 || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign drain         = vld_p1 && bus.out_ready;
    assign bus.out_valid = vld_p1;
    assign bus.out_inst  = inst_p1;
    assign bus.out_addr  = addr_p1;

    // Combinational encoder for the descriptor currently presented
    always_comb begin
        {enc_ok, enc_word} = encode(bus.op_sel, bus.rd, bus.rs1, bus.rs2, bus.imm);
    end

    // Session state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: a rejected last descriptor finishes at once, a legal one waits to drain
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                if ((accept && bus.in_last && !enc_ok) ||
                    (last_acc && (!vld_p1 || bus.out_ready)))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Session bookkeeping: address counter, last flag, error status
    always_ff @(posedge clk) begin
        if (rst) begin
            last_acc <= 1'b0;
            addr_cnt <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else if (start && (state != LOAD)) begin
            last_acc <= 1'b0;
            addr_cnt <= base_addr & ~{{(ADDR_W-2){1'b0}}, 2'b11};
            err      <= 1'b0;
            err_cnt  <= '0;
        end else if (accept) begin
            if (bus.in_last) last_acc <= 1'b1;
            if (enc_ok) begin
                addr_cnt <= addr_cnt + ADDR_W'(4);
            end else begin
                err     <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

    // ---- stage p1: one-deep output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            inst_p1 <= '0;
            addr_p1 <= '0;
        end else if (accept && enc_ok) begin
            vld_p1  <= 1'b1;
            inst_p1 <= enc_word;
            addr_p1 <= addr_cnt;
        end else if (drain) begin
            vld_p1  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: table of descriptors with hand-encoded words,
// a scoreboard queue for emitted words, and directed multi-cycle sequences.
module tb_inst_encoder_loader;

    localparam int ADDR_W = 32;
    localparam int ERR_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy, done, err;
    logic [ERR_W-1:0]  err_cnt;

    inst_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder_loader #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus.slave),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] imm;
        logic        last;
        logic        ok;
        logic [31:0] inst;
    } vec_t;

    typedef struct {
        logic [31:0]       inst;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        op;
        logic [63:0]       imm;
    } exp_t;

    vec_t              tbl [0:14];
    exp_t              sbq [$];
    exp_t              mon_e;
    int                n_vec = 0;
    int                n_bad = 0;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       held_inst;
    logic [ADDR_W-1:0] held_addr;
    vec_t              v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Immediate generator model: recovers the immediate from an encoded word
    function automatic logic [63:0] decode_imm(input logic [3:0] op, input logic [31:0] w);
        case (op)
            4'd2, 4'd3: return {{52{w[31]}}, w[31:25], w[11:7]};
            4'd7:       return {{52{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
            4'd8:       return {{44{w[31]}}, w[31], w[19:12], w[20], w[30:21]};
            default:    return {{52{w[31]}}, w[31:20]};
        endcase
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [63:0] imm, input logic last,
                                input logic ok, input logic [31:0] inst);
        vec_t r;
        r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        r.last = last; r.ok = ok; r.inst = inst;
        return r;
    endfunction

    // Output monitor: every word the memory takes is popped and compared
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_word: got %h @%h, want no word", bus.out_inst, bus.out_addr);
            end else begin
                mon_e = sbq.pop_front();
                check("out_inst", 64'(bus.out_inst), 64'(mon_e.inst));
                check("out_addr", 64'(bus.out_addr), 64'(mon_e.addr));
                check("roundtrip_imm", decode_imm(mon_e.op, bus.out_inst), mon_e.imm);
            end
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] base, input bit reload);
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1 start = 1'b0;
        if (reload) exp_addr = base;
    endtask

    task automatic send(input vec_t d, input bit chk_rdy);
        int guard;
        @(negedge clk);
        bus.op_sel = d.op; bus.rd = d.rd; bus.rs1 = d.rs1; bus.rs2 = d.rs2;
        bus.imm = d.imm; bus.in_last = d.last; bus.in_valid = 1'b1;
        if (chk_rdy) check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0, want 1 within 50 cycles");
            bus.in_valid = 1'b0;
            return;
        end
        if (d.ok) begin
            sbq.push_back('{d.inst, exp_addr, d.op, d.imm});
            exp_addr = exp_addr + 4;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!done && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("done", 64'(done), 64'd1);
        check("drained", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // addi, then one session of mixed legal and illegal descriptors
        tbl[0]  = mk(4'd4, 5'd1,  5'd0,  5'd0, 64'd5,                 1'b1, 1'b1, 32'h0050_0093);
        tbl[1]  = mk(4'd0, 5'd2,  5'd3,  5'd7, -64'sd8,               1'b0, 1'b1, 32'hFF81_B103);
        tbl[2]  = mk(4'd2, 5'd7,  5'd2,  5'd5, 64'd16,                1'b0, 1'b1, 32'h0051_3823);
        tbl[3]  = mk(4'd7, 5'd9,  5'd1,  5'd2, -64'sd2,               1'b0, 1'b1, 32'hFE20_8EE3);
        tbl[4]  = mk(4'd8, 5'd1,  5'd3,  5'd4, -64'sd524288,          1'b0, 1'b1, 32'h8000_00EF);
        tbl[5]  = mk(4'd8, 5'd1,  5'd0,  5'd0, 64'd524287,            1'b0, 1'b1, 32'h7FFF_F0EF);
        tbl[6]  = mk(4'd3, 5'd3,  5'd4,  5'd6, -64'sd1,               1'b0, 1'b1, 32'hFE62_2FA3);
        tbl[7]  = mk(4'd5, 5'd7,  5'd8,  5'd0, -64'sd2048,            1'b0, 1'b1, 32'h8004_2393);
        tbl[8]  = mk(4'd6, 5'd1,  5'd5,  5'd9, 64'd2047,              1'b0, 1'b1, 32'h7FF2_80E7);
        tbl[9]  = mk(4'd1, 5'd10, 5'd11, 5'd0, 64'd0,                 1'b0, 1'b1, 32'h0005_A503);
        tbl[10] = mk(4'd7, 5'd0,  5'd1,  5'd2, 64'd2048,              1'b0, 1'b0, 32'h0);
        tbl[11] = mk(4'd8, 5'd1,  5'd0,  5'd0, 64'd524288,            1'b0, 1'b0, 32'h0);
        tbl[12] = mk(4'd4, 5'd1,  5'd0,  5'd0, -64'sd2049,            1'b0, 1'b0, 32'h0);
        tbl[13] = mk(4'd9, 5'd1,  5'd0,  5'd0, 64'd0,                 1'b0, 1'b0, 32'h0);
        tbl[14] = mk(4'd0, 5'd0,  5'd0,  5'd0, 64'd1,                 1'b1, 1'b1, 32'h0010_3003);

        rst = 1'b1; start = 1'b0; base_addr = '0; exp_addr = '0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.op_sel = '0; bus.rd = '0;
        bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_inst",  64'(bus.out_inst),  64'd0);
        check("rst_out_addr",  64'(bus.out_addr),  64'd0);
        check("rst_busy",      64'(busy),          64'd0);
        check("rst_done",      64'(done),          64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_err_cnt",   64'(err_cnt),       64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // single addi session
        do_start(32'h100, 1'b1);
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'd1);
        send(tbl[0], 1'b0);
        wait_done();
        check("busy_in_done", 64'(busy), 64'd0);

        // table session, back-to-back with the memory always ready
        do_start(32'h1000, 1'b1);
        for (int i = 1; i <= 14; i++) send(tbl[i], 1'b1);
        wait_done();
        check("err_tbl", 64'(err), 64'd1);
        check("err_cnt_tbl", 64'(err_cnt), 64'd4);

        // rejects leave out_addr and the address counter alone
        do_start(32'h40, 1'b1);
        @(negedge clk);
        check("done_cleared", 64'(done), 64'd0);
        check("err_cleared", 64'(err), 64'd0);
        check("err_cnt_cleared", 64'(err_cnt), 64'd0);
        send(mk(4'd4, 5'd1, 5'd0, 5'd0, 64'd2048, 1'b0, 1'b0, 32'h0), 1'b0);
        send(mk(4'd12, 5'd1, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0, 32'h0), 1'b0);
        @(negedge clk);
        check("err_rej", 64'(err), 64'd1);
        check("err_cnt_rej", 64'(err_cnt), 64'd2);
        check("no_emit_rej", 64'(bus.out_valid), 64'd0);
        check("out_addr_held", 64'(bus.out_addr), 64'h1024);
        send(mk(4'd4, 5'd3, 5'd3, 5'd0, -64'sd1, 1'b1, 1'b1, 32'hFFF1_8193), 1'b0);
        wait_done();

        // backpressure stall, then an ignored start while loading
        do_start(32'h200, 1'b1);
        bus.out_ready = 1'b0;
        send(mk(4'd4, 5'd1, 5'd0, 5'd0, 64'd1, 1'b0, 1'b1, 32'h0010_0093), 1'b0);
        held_inst = 32'h0010_0093;
        held_addr = 32'h200;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_out_inst", 64'(bus.out_inst), 64'(held_inst));
            check("stall_out_addr", 64'(bus.out_addr), 64'(held_addr));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        do_start(32'h800, 1'b0);
        send(tbl[9], 1'b0);
        v = tbl[9];
        v.last = 1'b1;
        send(v, 1'b0);
        wait_done();

        // address counter wraps past the top of the address space
        do_start(32'hFFFF_FFFC, 1'b1);
        send(mk(4'd4, 5'd1, 5'd0, 5'd0, 64'd5, 1'b0, 1'b1, 32'h0050_0093), 1'b0);
        send(mk(4'd4, 5'd1, 5'd0, 5'd0, 64'd5, 1'b1, 1'b1, 32'h0050_0093), 1'b0);
        wait_done();

        // error counter saturates; a rejected last finishes on the next cycle
        do_start(32'h0, 1'b1);
        for (int k = 0; k < 260; k++)
            send(mk(4'd15, 5'd0, 5'd0, 5'd0, 64'd0, (k == 259), 1'b0, 32'h0), 1'b0);
        @(negedge clk);
        check("done_after_rej_last", 64'(done), 64'd1);
        check("err_cnt_sat", 64'(err_cnt), 64'hFF);

        // reset mid-session with a word pending
        do_start(32'h300, 1'b1);
        bus.out_ready = 1'b0;
        send(mk(4'd4, 5'd1, 5'd0, 5'd0, 64'd5, 1'b0, 1'b1, 32'h0050_0093), 1'b0);
        @(negedge clk);
        check("pending_before_rst", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_out_inst", 64'(bus.out_inst), 64'd0);
        check("mid_rst_out_addr", 64'(bus.out_addr), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
Program-side counterpart of the decode-stage immediate generator. It takes symbolic instructions (op select, register fields, 64-bit immediate), range-checks them, packs them into 32-bit RV64I words, and streams them with consecutive byte addresses to the instruction-memory write port. It is used by the test/boot loader to fill instruction memory before the pipeline is released. Round-trip rule: decoding an emitted word with the immediate generator returns the input immediate exactly.

Parameters:
ADDR_W, 32, width of instruction-memory byte address
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; begins a load session at base_addr
base_addr  input  ADDR_W  byte address of first emitted word; must be 4-aligned
in_valid  input  1  instruction descriptor valid
in_ready  output  1  descriptor accepted when in_valid && in_ready
in_last  input  1  marks final descriptor of session
op_sel  input  4  0 ld, 1 lw, 2 sd, 3 sw, 4 addi, 5 slti, 6 jalr, 7 beq, 8 jal; 9-15 illegal
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
imm  input  64  signed immediate, in immediate-generator units
out_valid  output  1  encoded word valid
out_ready  input  1  memory accepts word
out_inst  output  32  encoded instruction
out_addr  output  ADDR_W  byte address for out_inst
busy  output  1  session in progress
done  output  1  level; session finished and drained
err  output  1  sticky; any descriptor rejected this session
err_cnt  output  ERR_W  rejected descriptors this session; saturates at all-ones

Behaviour:
- Reset (sync, active-high): state IDLE, all outputs 0, address counter 0. A reset asserted mid-session discards the output register contents without emitting them.
- States: IDLE, LOAD, DONE.
  - IDLE or DONE, start=1 -> LOAD. Address counter <= base_addr; err, err_cnt and done are cleared.
  - start while in LOAD is ignored.
  - In LOAD, when the last descriptor has been accepted and the output register is empty or draining this cycle -> DONE, done=1.
- busy = (state==LOAD).
- in_ready = busy && (!out_valid || out_ready). The block never accepts a descriptor in IDLE or DONE.
- Latency: descriptor accepted in cycle N -> out_valid/out_inst/out_addr valid in cycle N+1. The output register is one deep.
- While out_valid && !out_ready: out_inst and out_addr hold stable and in_ready=0.
- Address counter advances by 4 only for emitted (legal) words, and wraps modulo 2^ADDR_W.
- Encoding (opcode / funct3):
  - ld 0000011/011, lw 0000011/010: I-type.
  - sd 0100011/011, sw 0100011/010: S-type.
  - addi 0010011/000, slti 0010011/010, jalr 1100111/000: I-type.
  - beq 1100011/000: B-type.
  - jal 1101111: J-type.
- Immediate legality: imm must equal the sign-extension of its low bits.
  - I/S types: 12 bits, range -2048..2047.
  - beq: 12-bit field in halfword units, range -2048..2047. Placement: imm[11]->bit31, imm[10]->bit7, imm[9:4]->30:25, imm[3:0]->11:8.
  - jal: 20-bit field, range -524288..524287. Placement: imm[19]->31, imm[18:11]->19:12, imm[10]->20, imm[9:0]->30:21.
- Unused register fields are zeroed in the output: rs2 for I-type, rd for S/B-type, rs1/rs2 for J-type.
- Illegal op_sel or out-of-range imm:
  - The descriptor is accepted (handshake completes) but no word is emitted.
  - err is set and err_cnt increments (saturating).
  - If in_last is set on that descriptor, the session still completes.
- The last descriptor being rejected with the output register empty -> DONE on the next cycle.

Test Plan:
- start, base_addr=0x100; addi rd=1 rs1=0 imm=5, last -> out_inst=0x00500093, out_addr=0x100 one cycle after accept; done=1 afterwards.
- ld rd=2 rs1=3 imm=-8, then sd rs1=2 rs2=5 imm=16 (last), out_ready=1 -> 0xFF81B103 @base, then 0x00513823 @base+4; back-to-back with in_ready held high.
- beq rs1=1 rs2=2 imm=-2 -> 0xFE208EE3; feeding this word to the immediate generator returns 0xFFFFFFFFFFFFFFFE. Cover the same round-trip for jal with imm=-524288 and 524287.
- addi imm=2048, then op_sel=12 -> nothing emitted, err=1, err_cnt=2, out_addr unchanged; the next legal word still uses the base address.
- out_ready=0 for 3 cycles with a word pending -> in_ready=0, out_inst/out_addr stable; the word drains on release, then the next is accepted.
- rst asserted mid-session with out_valid=1 -> next cycle all outputs 0, state IDLE. start during LOAD -> address counter not reloaded.
